// File: rtl/mult32_seq.sv
// Iterative unsigned 32x32->64 shift-add multiplier built around a single add32.
// One partial-product step per clock; valid/ready on both sides, one operation in flight.

module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [8:0]  gc;

  assign g     = a & b;
  assign p     = a ^ b;
  assign gc[0] = c_in;

  // 4-bit lookahead groups, rippled group-to-group
  for (genvar k = 0; k < 8; k++) begin : g_grp
    logic [3:0] gg;
    logic [3:0] pp;

    assign gg = g[4*k +: 4];
    assign pp = p[4*k +: 4];

    assign c[4*k]     = gc[k];
    assign c[4*k + 1] = gg[0] | (pp[0] & gc[k]);
    assign c[4*k + 2] = gg[1] | (pp[1] & gg[0]) | ((&pp[1:0]) & gc[k]);
    assign c[4*k + 3] = gg[2] | (pp[2] & gg[1]) | ((&pp[2:1]) & gg[0])
                      | ((&pp[2:0]) & gc[k]);
    assign gc[k + 1]  = gg[3] | (pp[3] & gg[2]) | ((&pp[3:2]) & gg[1])
                      | ((&pp[3:1]) & gg[0]) | ((&pp) & gc[k]);
  end

  assign sum   = p ^ c;
  assign c_out = gc[8];

endmodule

module mult32_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  if (WIDTH != 32) begin : g_width_check
    $error("mult32_seq: WIDTH must be 32 because the adder is add32");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [4:0]         count;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] acc_nxt;

  assign add_b = acc[0] ? mcand : '0;

  add32 u_add32 (
    .a     (acc[2*WIDTH-1:WIDTH]),
    .b     (add_b),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  // The adder carry becomes the new MSB after the shift, so max*max stays exact.
  assign acc_nxt = {add_cout, add_sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      mcand     <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= a;
            acc      <= {{WIDTH{1'b0}}, b};
            count    <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            product   <= acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult32_seq.sv
// Randomized self-checking bench for mult32_seq against a 64-bit arithmetic reference.

module tb_mult32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] product;

  int n_checks = 0;
  int n_err = 0;

  mult32_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; stall holds out_ready low in DONE, poke drives
  // foreign operands during RUN that must be ignored.
  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob,
                       input int stall, input bit poke);
    logic [63:0] exp;
    int n;
    exp = 64'(oa) * 64'(ob);
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a = oa;
    b = ob;
    tick();
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    check("in_ready_run", 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      if (poke && n == 5) begin
        in_valid = 1'b1;
        a = ~oa;
        b = ob + 32'd1;
      end
      if (poke && n == 9) in_valid = 1'b0;
      tick();
      n++;
      if (poke && n < 32) check("in_ready_busy", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    check("latency", 64'(n), 64'd32);
    check("product", product, exp);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_product", product, exp);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_clr", 64'(out_valid), 64'd0);
    check("product_hold", product, exp);
    check("in_ready_back", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", product, 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid2", 64'(out_valid), 64'd0);

    do_op(32'd3, 32'd5, 0, 1'b0);
    check("const_3x5", product, 64'd15);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check("const_max", product, 64'hFFFF_FFFE_0000_0001);
    do_op(32'd0, 32'h1234, 0, 1'b0);
    check("const_zero", product, 64'h0);
    do_op(32'h8000_0000, 32'd2, 0, 1'b0);
    check("const_msb", product, 64'h1_0000_0000);
    do_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 10, 1'b1);

    // Abort mid-RUN with asynchronous reset after 17 steps
    in_valid = 1'b1;
    a = 32'h1357_9BDF;
    b = 32'h2468_ACE0;
    tick();
    in_valid = 1'b0;
    repeat (17) tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_idle_valid", 64'(out_valid), 64'd0);
    do_op(32'h0001_0001, 32'hFFFF_0000, 1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'd0;
        3: rb = 32'd1;
        default: ;
      endcase
      do_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
